// File: rtl/risc_mc_core.sv
// risc_mc_core: multicycle RISC core, eight registers, C/Z flags and a single
// request/ready memory port. FSM state and halt status are exposed for debug.
module risc_mc_core #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [2:0]        state_id,
    output logic              halted
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        HALT   = 3'd7
    } state_t;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_ADI = 4'b0001;
    localparam logic [3:0] OP_NDU = 4'b0010;
    localparam logic [3:0] OP_LHI = 4'b0011;
    localparam logic [3:0] OP_LW  = 4'b0100;
    localparam logic [3:0] OP_SW  = 4'b0101;
    localparam logic [3:0] OP_JAL = 4'b1000;
    localparam logic [3:0] OP_JLR = 4'b1001;
    localparam logic [3:0] OP_BEQ = 4'b1100;

    state_t            state;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] regs [8];
    logic              c_flag;
    logic              z_flag;
    logic [15:0]       ir;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] result;
    logic [2:0]        dest;

    logic [3:0]        opcode;
    logic [2:0]        ra, rb, rc;
    logic [1:0]        cz;
    logic [DATA_W-1:0] imm6_sx;
    logic [DATA_W-1:0] imm9_sx;
    logic [DATA_W-1:0] add_rhs;
    logic [DATA_W:0]   add_full;
    logic [DATA_W-1:0] nand_val;
    logic [DATA_W-1:0] lhi_val;
    logic [ADDR_W-1:0] ea;
    logic [DATA_W-1:0] pc_inc;
    logic [DATA_W-1:0] exec_npc;
    logic              cond_ok;
    logic              known_op;
    logic              is_cond_op;
    logic              short_path;

    assign opcode = ir[15:12];
    assign ra     = ir[11:9];
    assign rb     = ir[8:6];
    assign rc     = ir[5:3];
    assign cz     = ir[1:0];

    assign state_id = state;
    assign halted   = (state == HALT);

    // Datapath: ALU, effective address, next-PC and decode qualifiers
    always_comb begin
        imm6_sx    = {{(DATA_W-6){ir[5]}}, ir[5:0]};
        imm9_sx    = {{(DATA_W-9){ir[8]}}, ir[8:0]};
        add_rhs    = (opcode == OP_ADI) ? imm6_sx : op_b;
        add_full   = {1'b0, op_a} + {1'b0, add_rhs};
        nand_val   = ~(op_a & op_b);
        lhi_val    = '0;
        lhi_val[15:7] = ir[8:0];
        // Address math only needs the low ADDR_W bits; truncation commutes with the add
        ea         = op_b[ADDR_W-1:0] + imm6_sx[ADDR_W-1:0];
        pc_inc     = pc + DATA_W'(1);
        is_cond_op = (opcode == OP_ADD) || (opcode == OP_NDU);
        case (cz)
            2'b10:   cond_ok = c_flag;
            2'b01:   cond_ok = z_flag;
            default: cond_ok = 1'b1;
        endcase
        case (opcode)
            OP_BEQ:  exec_npc = (op_a == op_b) ? (pc + imm6_sx) : pc_inc;
            OP_JAL:  exec_npc = pc + imm9_sx;
            OP_JLR:  exec_npc = op_b;
            default: exec_npc = pc_inc;
        endcase
        case (opcode)
            OP_ADD, OP_ADI, OP_NDU, OP_LHI, OP_LW, OP_SW,
            OP_JAL, OP_JLR, OP_BEQ: known_op = 1'b1;
            default:                known_op = 1'b0;
        endcase
        short_path = (opcode == OP_BEQ) || (opcode == OP_JAL) ||
                     (opcode == OP_JLR) || (is_cond_op && !cond_ok);
    end

    // Control FSM with registered memory-port outputs and architectural state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pc        <= '0;
            for (int unsigned i = 0; i < 8; i++) regs[i] <= '0;
            c_flag    <= 1'b0;
            z_flag    <= 1'b0;
            ir        <= '0;
            op_a      <= '0;
            op_b      <= '0;
            result    <= '0;
            dest      <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    state    <= FETCH;
                    mem_req  <= 1'b1;
                    mem_we   <= 1'b0;
                    mem_addr <= pc[ADDR_W-1:0];
                end
                FETCH: begin
                    if (mem_ready) begin
                        ir      <= mem_rdata[15:0];
                        mem_req <= 1'b0;
                        state   <= DECODE;
                    end
                end
                DECODE: begin
                    op_a <= regs[ra];
                    op_b <= regs[rb];
                    if (!known_op || (is_cond_op && cz == 2'b11)) state <= HALT;
                    else                                          state <= EXEC;
                end
                EXEC: begin
                    if (short_path) begin
                        if (opcode == OP_JAL || opcode == OP_JLR) regs[ra] <= pc_inc;
                        pc       <= exec_npc;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= exec_npc[ADDR_W-1:0];
                        state    <= FETCH;
                    end else begin
                        case (opcode)
                            OP_ADD, OP_ADI: begin
                                result <= add_full[DATA_W-1:0];
                                c_flag <= add_full[DATA_W];
                                z_flag <= (add_full[DATA_W-1:0] == '0);
                                dest   <= (opcode == OP_ADD) ? rc : rb;
                                state  <= WB;
                            end
                            OP_NDU: begin
                                result <= nand_val;
                                z_flag <= (nand_val == '0);
                                dest   <= rc;
                                state  <= WB;
                            end
                            OP_LHI: begin
                                result <= lhi_val;
                                dest   <= ra;
                                state  <= WB;
                            end
                            OP_LW, OP_SW: begin
                                mem_req   <= 1'b1;
                                mem_we    <= (opcode == OP_SW);
                                mem_addr  <= ea;
                                mem_wdata <= op_a;
                                dest      <= ra;
                                state     <= MEM;
                            end
                            default: state <= HALT;
                        endcase
                    end
                end
                MEM: begin
                    if (mem_ready) begin
                        if (mem_we) begin
                            mem_we   <= 1'b0;
                            pc       <= pc_inc;
                            mem_addr <= pc_inc[ADDR_W-1:0];
                            state    <= FETCH;
                        end else begin
                            result  <= mem_rdata;
                            z_flag  <= (mem_rdata == '0);
                            mem_req <= 1'b0;
                            state   <= WB;
                        end
                    end
                end
                WB: begin
                    regs[dest] <= result;
                    pc         <= pc_inc;
                    mem_req    <= 1'b1;
                    mem_we     <= 1'b0;
                    mem_addr   <= pc_inc[ADDR_W-1:0];
                    state      <= FETCH;
                end
                HALT: begin
                    mem_req <= 1'b0;
                    mem_we  <= 1'b0;
                end
                default: begin
                    mem_req <= 1'b0;
                    mem_we  <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_risc_mc_core.sv
// tb_risc_mc_core: memory model with programmable store wait states and a
// scoreboard of expected memory accesses (kind, address, store data, and the
// number of cycles since the previous completed access).
module tb_risc_mc_core;

    logic        clk;
    logic        rst_n;
    logic        mem_req;
    logic        mem_we;
    logic [5:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ready;
    logic [2:0]  state_id;
    logic        halted;

    risc_mc_core #(.DATA_W(16), .ADDR_W(6)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .state_id  (state_id),
        .halted    (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        int          addr;
        logic [15:0] data;
        int          gap;
    } acc_t;

    acc_t        sb [$];
    logic [15:0] mem [64];
    int          n_chk = 0;
    int          n_err = 0;
    int          n_wr  = 0;
    int          wait_wr = 0;
    int          cyc, last_edge, stall, wr_cyc;
    logic [5:0]  hold_addr;
    logic [15:0] hold_data;

    assign mem_rdata = mem[mem_addr];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] enc_r(input int op, input int ra, input int rb,
                                          input int rc, input int cz);
        enc_r = {op[3:0], ra[2:0], rb[2:0], rc[2:0], 1'b0, cz[1:0]};
    endfunction
    function automatic logic [15:0] enc_i6(input int op, input int ra, input int rb, input int imm);
        enc_i6 = {op[3:0], ra[2:0], rb[2:0], imm[5:0]};
    endfunction
    function automatic logic [15:0] enc_i9(input int op, input int ra, input int imm);
        enc_i9 = {op[3:0], ra[2:0], imm[8:0]};
    endfunction

    task automatic exp_f(input int addr, input int gap);
        acc_t e; e.we = 1'b0; e.addr = addr; e.data = '0; e.gap = gap; sb.push_back(e);
    endtask
    task automatic exp_w(input int addr, input int data, input int gap);
        acc_t e; e.we = 1'b1; e.addr = addr; e.data = data[15:0]; e.gap = gap; sb.push_back(e);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 64; i++) mem[i] = '0;
    endtask

    // Memory model: drives ready on the falling edge and scores the access
    // that will complete on the following rising edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            cyc = 0; last_edge = 0; stall = 0; wr_cyc = 0; mem_ready = 1'b1;
        end else begin
            cyc++;
            if (mem_req && mem_we && stall < wait_wr) begin
                mem_ready = 1'b0;
                stall++;
            end else begin
                mem_ready = 1'b1;
            end
            if (mem_req && mem_we) begin
                if (wr_cyc == 0) begin
                    hold_addr = mem_addr;
                    hold_data = mem_wdata;
                end else begin
                    chk("hold_addr", mem_addr, hold_addr);
                    chk("hold_data", mem_wdata, hold_data);
                end
                wr_cyc++;
            end
            if (mem_req && mem_ready) begin
                automatic int edge_no = cyc + 1;
                automatic int gap = edge_no - last_edge;
                last_edge = edge_no;
                if (sb.size() == 0) begin
                    chk("extra_access", sb.size(), 1);
                end else begin
                    automatic acc_t e = sb.pop_front();
                    chk("acc_we", mem_we, e.we);
                    chk("acc_addr", mem_addr, e.addr);
                    chk("acc_gap", gap, e.gap);
                    if (e.we) chk("acc_data", mem_wdata, e.data);
                end
                if (mem_we) begin
                    mem[mem_addr] = mem_wdata;
                    n_wr++;
                    chk("wr_hold_cycles", wr_cyc, wait_wr + 1);
                end
                stall = 0;
                wr_cyc = 0;
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_req", mem_req, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_state", state_id, 0);
        chk("rst_halted", halted, 0);
        #1 rst_n = 1'b1;
    endtask

    task automatic run_to_halt();
        int t = 0;
        while (!halted && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk("halt_reached", halted, 1);
        chk("state_halt", state_id, 7);
        repeat (8) @(negedge clk);
        chk("req_in_halt", mem_req, 0);
        chk("sb_empty", sb.size(), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        mem_ready = 1'b1;

        // A: ADI, skipped conditionals with C=Z=0, first-request timing
        clear_mem(); wait_wr = 0;
        mem[0] = enc_i6(1, 0, 1, 5);        // ADI R1,R0,5
        mem[1] = enc_r(0, 1, 1, 2, 1);      // ADD R2,R1,R1 cz=01 (skip)
        mem[2] = enc_r(0, 1, 1, 2, 2);      // ADD R2,R1,R1 cz=10 (skip)
        mem[3] = enc_i6(5, 1, 0, 20);       // SW R1 -> 20
        mem[4] = enc_i6(5, 2, 0, 21);       // SW R2 -> 21
        mem[5] = 16'h6000;
        exp_f(0, 2); exp_f(1, 4); exp_f(2, 3); exp_f(3, 3);
        exp_w(20, 5, 3); exp_f(4, 1); exp_w(21, 0, 3); exp_f(5, 1);
        do_reset();
        chk("req_idle", mem_req, 0);
        @(posedge clk); #1;
        chk("req_cycle2", mem_req, 1);
        run_to_halt();

        // B: carry/zero flags and conditional execution
        clear_mem(); wait_wr = 0;
        mem[0]  = enc_i6(1, 0, 1, -1);      // R1=FFFF
        mem[1]  = enc_i6(1, 0, 2, 1);       // R2=1
        mem[2]  = enc_r(0, 1, 2, 3, 0);     // R3=0, C=1 Z=1
        mem[3]  = enc_r(0, 1, 1, 4, 1);     // Z=1: R4=FFFE, C=1 Z=0
        mem[4]  = enc_r(0, 4, 2, 5, 2);     // C=1: R5=FFFF, C=0 Z=0
        mem[5]  = enc_r(2, 1, 2, 6, 1);     // NDU, Z=0: skipped
        mem[6]  = enc_r(0, 1, 1, 7, 2);     // ADD, C=0: skipped
        for (int i = 0; i < 5; i++) mem[7+i] = enc_i6(5, 3+i, 0, 24+i);
        mem[12] = 16'h7000;
        exp_f(0, 2); exp_f(1, 4); exp_f(2, 4); exp_f(3, 4); exp_f(4, 4);
        exp_f(5, 4); exp_f(6, 3); exp_f(7, 3);
        exp_w(24, 16'h0000, 3); exp_f(8, 1);
        exp_w(25, 16'hFFFE, 3); exp_f(9, 1);
        exp_w(26, 16'hFFFF, 3); exp_f(10, 1);
        exp_w(27, 16'h0000, 3); exp_f(11, 1);
        exp_w(28, 16'h0000, 3); exp_f(12, 1);
        do_reset();
        run_to_halt();

        // C: store address wrap, store wait states, load-use
        clear_mem(); wait_wr = 3;
        mem[0] = enc_i6(1, 0, 1, 7);        // R1=7
        mem[1] = enc_i6(1, 0, 2, 31);
        mem[2] = enc_i6(1, 2, 2, 31);
        mem[3] = enc_i6(1, 2, 2, 1);        // R2=0x3F
        mem[4] = enc_i6(5, 1, 2, 1);        // SW R1 -> 0x40 wraps to 0
        mem[5] = enc_i6(4, 3, 0, 0);        // LW R3 <- 0
        mem[6] = enc_i6(5, 3, 0, 30);       // SW R3 -> 30
        mem[7] = 16'hA000;
        exp_f(0, 2); exp_f(1, 4); exp_f(2, 4); exp_f(3, 4); exp_f(4, 4);
        exp_w(0, 7, 6); exp_f(5, 1); exp_f(0, 3); exp_f(6, 2);
        exp_w(30, 7, 6); exp_f(7, 1);
        do_reset();
        run_to_halt();

        // D: BEQ loop back, JAL, JLR with ra==rb
        clear_mem(); wait_wr = 0;
        mem[0]  = enc_i6(1, 0, 4, 1);       // R4=1
        mem[1]  = enc_i6(1, 0, 2, 0);       // R2=0
        mem[2]  = enc_i6(1, 2, 2, 1);       // R2++
        mem[3]  = enc_i6(5, 2, 0, 24);      // SW R2 -> 24
        mem[4]  = enc_i6(12, 2, 4, -2);     // BEQ R2,R4,-2
        mem[5]  = enc_i9(8, 6, 5);          // JAL R6,+5
        mem[10] = enc_i9(8, 7, 9);          // JAL R7,+9
        mem[19] = enc_i6(5, 7, 0, 25);
        mem[20] = enc_i6(5, 6, 0, 27);
        mem[21] = enc_i6(1, 0, 5, 31);
        mem[22] = enc_i6(1, 5, 5, 1);       // R5=0x20
        mem[23] = enc_i6(9, 5, 5, 0);       // JLR R5,R5
        mem[32] = enc_i6(5, 5, 0, 26);
        mem[33] = 16'hF000;
        exp_f(0, 2); exp_f(1, 4); exp_f(2, 4); exp_f(3, 4);
        exp_w(24, 1, 3); exp_f(4, 1); exp_f(2, 3); exp_f(3, 4);
        exp_w(24, 2, 3); exp_f(4, 1); exp_f(5, 3); exp_f(10, 3); exp_f(19, 3);
        exp_w(25, 11, 3); exp_f(20, 1); exp_w(27, 6, 3); exp_f(21, 1);
        exp_f(22, 4); exp_f(23, 4); exp_f(32, 3); exp_w(26, 24, 3); exp_f(33, 1);
        do_reset();
        run_to_halt();

        // E: illegal cz=11 halts; reset restarts from PC 0
        clear_mem(); wait_wr = 0;
        mem[0] = enc_i6(1, 0, 1, 1);
        mem[1] = enc_r(0, 1, 1, 2, 3);
        exp_f(0, 2); exp_f(1, 4);
        do_reset();
        run_to_halt();
        exp_f(0, 2); exp_f(1, 4);
        do_reset();
        run_to_halt();

        // F: reset asserted while a store is stalled
        clear_mem(); wait_wr = 100;
        mem[0] = enc_i6(1, 0, 1, 9);
        mem[1] = enc_i6(5, 1, 0, 28);
        exp_f(0, 2); exp_f(1, 4);
        do_reset();
        begin
            int t = 0;
            int wr_before;
            wr_before = n_wr;
            while (!mem_we && t < 200) begin
                @(negedge clk);
                t++;
            end
            chk("store_started", mem_we, 1);
            @(posedge clk); @(posedge clk);
            #2 rst_n = 1'b0;
            #1;
            chk("async_req", mem_req, 0);
            chk("async_we", mem_we, 0);
            chk("async_state", state_id, 0);
            repeat (3) @(negedge clk);
            chk("no_write", n_wr - wr_before, 0);
            chk("mem28_clean", mem[28], 0);
            chk("sb_empty_f", sb.size(), 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
